hazard_scoreboard: RTL and testbench

- Parametrised successor to the per-opcode stall controller for the 5-stage RISC-V core.
- Replaces fixed opcode/stage comparisons with a per-register scoreboard of in-flight writes.
- Each in-flight write carries a countdown counter, so one block covers ALU, load, multi-cycle mul/div and unknown-latency (cache-miss) results.
- Sits beside decode; its stall output freezes IF/ID and bubbles ID/EX.

---
 rtl/hazard_scoreboard.sv | 137 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register scoreboard of in-flight writes for the
// 5-stage core. Each architectural register (except x0) holds a countdown
// of cycles until its pending result becomes usable, plus an "unknown
// latency" flag that only a writeback commit clears.
//
// Ports:
//   clk, reset                      core clock, synchronous active-high reset
//   id_valid_ip                     ID holds a valid instruction
//   id_src{1,2}_addr_ip/_use_ip     source register addresses and use flags
//   id_dest_addr_ip, id_write_en_ip destination register and write flag
//   id_latency_ip                   result latency (0 = unknown)
//   flush_ip                        squash the ID instruction this cycle
//   wb_valid_ip, wb_dest_addr_ip    commit of an unknown-latency result
//   stall_op                        hold ID (freeze IF/ID, bubble ID/EX)
//   pending_mask_op                 bit r set while register r is not usable
//   busy_op                         any register pending

// One scoreboard entry: countdown counter + unknown-latency flag.
module hs_entry #(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_i,   // an issuing instruction targets this reg
  input  logic             known_i,   // issuing latency is known (non-zero)
  input  logic [LAT_W-1:0] eff_i,     // cycles until usable, already saturated
  input  logic             wb_clr_i,  // writeback commit to this reg
  output logic [LAT_W-1:0] cnt_o,
  output logic             unk_o,
  output logic             pending_o
);
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             unk_q, unk_d;

  // Issue overrides both the wb clear and the decrement.
  always_comb begin
    cnt_d = cnt_q;
    unk_d = unk_q;
    if (issue_i) begin
      cnt_d = known_i ? eff_i : '0;
      unk_d = !known_i;
    end else begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      if (wb_clr_i)    unk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      unk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      unk_q <= unk_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign unk_o     = unk_q;
  assign pending_o = (cnt_q != '0) | unk_q;
endmodule

module hazard_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LAT    = 15,
  parameter int LAT_W      = 4,
  parameter int FORWARD_EN = 1,
  parameter int WB_DIST    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid_ip,
  input  logic [REG_ADDR_W-1:0] id_src1_addr_ip,
  input  logic                  id_src1_use_ip,
  input  logic [REG_ADDR_W-1:0] id_src2_addr_ip,
  input  logic                  id_src2_use_ip,
  input  logic [REG_ADDR_W-1:0] id_dest_addr_ip,
  input  logic                  id_write_en_ip,
  input  logic [LAT_W-1:0]      id_latency_ip,
  input  logic                  flush_ip,
  input  logic                  wb_valid_ip,
  input  logic [REG_ADDR_W-1:0] wb_dest_addr_ip,
  output logic                  stall_op,
  output logic [NUM_REGS-1:0]   pending_mask_op,
  output logic                  busy_op
);
  localparam int CNT_MAX = (1 << LAT_W) - 1;
  localparam int EXTRA   = (FORWARD_EN != 0) ? 0 : WB_DIST;

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            unk;
  logic [NUM_REGS-1:0]            pend;
  logic [31:0]                    eff_wide;
  logic [LAT_W-1:0]               eff;
  logic                           lat_known;
  logic                           raw1, raw2, waw, issue;

  // Effective latency; a zero (unknown) latency wraps here but is never
  // loaded because lat_known gates it.
  always_comb begin
    eff_wide = 32'(id_latency_ip) + 32'(EXTRA) - 32'd1;
    eff      = (eff_wide > 32'(CNT_MAX)) ? LAT_W'(CNT_MAX) : eff_wide[LAT_W-1:0];
  end
  assign lat_known = (id_latency_ip != '0);

  assign raw1 = id_src1_use_ip && (id_src1_addr_ip != '0) && pend[id_src1_addr_ip];
  assign raw2 = id_src2_use_ip && (id_src2_addr_ip != '0) && pend[id_src2_addr_ip];
  // An older write must not land after the younger one to the same reg.
  assign waw  = id_write_en_ip && (id_dest_addr_ip != '0) &&
                (unk[id_dest_addr_ip] || (cnt[id_dest_addr_ip] > eff));

  assign stall_op = id_valid_ip && (raw1 || raw2 || waw);
  assign issue    = id_valid_ip && !stall_op && !flush_ip && id_write_en_ip;

  // x0 is hard-wired: no state, never pending.
  assign cnt[0]  = '0;
  assign unk[0]  = 1'b0;
  assign pend[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    hs_entry #(.LAT_W(LAT_W)) u_ent (
      .clk       (clk),
      .reset     (reset),
      .issue_i   (issue && (id_dest_addr_ip == REG_ADDR_W'(r))),
      .known_i   (lat_known),
      .eff_i     (eff),
      .wb_clr_i  (wb_valid_ip && (wb_dest_addr_ip == REG_ADDR_W'(r))),
      .cnt_o     (cnt[r]),
      .unk_o     (unk[r]),
      .pending_o (pend[r])
    );
  end

  assign pending_mask_op = pend;
  assign busy_op         = |pend;
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, s1_use, s2_use, we, flush, wb_valid;
  logic [4:0]  s1, s2, rd, wb_dest;
  logic [3:0]  lat;
  logic        stall1, busy1, stall0, busy0;
  logic [31:0] mask1, mask0;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  // dut1: bypass present; dut0: results usable only after register commit.
  hazard_scoreboard #(.FORWARD_EN(1)) dut1 (
    .clk(clk), .reset(reset), .id_valid_ip(id_valid),
    .id_src1_addr_ip(s1), .id_src1_use_ip(s1_use),
    .id_src2_addr_ip(s2), .id_src2_use_ip(s2_use),
    .id_dest_addr_ip(rd), .id_write_en_ip(we), .id_latency_ip(lat),
    .flush_ip(flush), .wb_valid_ip(wb_valid), .wb_dest_addr_ip(wb_dest),
    .stall_op(stall1), .pending_mask_op(mask1), .busy_op(busy1));

  hazard_scoreboard #(.FORWARD_EN(0), .WB_DIST(3)) dut0 (
    .clk(clk), .reset(reset), .id_valid_ip(id_valid),
    .id_src1_addr_ip(s1), .id_src1_use_ip(s1_use),
    .id_src2_addr_ip(s2), .id_src2_use_ip(s2_use),
    .id_dest_addr_ip(rd), .id_write_en_ip(we), .id_latency_ip(lat),
    .flush_ip(flush), .wb_valid_ip(wb_valid), .wb_dest_addr_ip(wb_dest),
    .stall_op(stall0), .pending_mask_op(mask0), .busy_op(busy0));

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic idle();
    id_valid = 0; s1_use = 0; s2_use = 0; we = 0; flush = 0; wb_valid = 0;
    s1 = 0; s2 = 0; rd = 0; wb_dest = 0; lat = 0;
  endtask

  // Issue a write with no sources; called and returns at posedge+1.
  task automatic issue(input int dst, input int l);
    id_valid = 1; we = 1; rd = 5'(dst); lat = 4'(l);
    @(posedge clk); #1 idle();
  endtask

  // Expected stall count is queued when the consumer is driven, then popped
  // once the selected DUT releases the stall.
  task automatic measure(input bit use_fe0, input string tag, input int exp);
    int n = 0;
    exp_q.push_back(exp);
    forever begin
      @(negedge clk);
      if (!(use_fe0 ? stall0 : stall1)) break;
      n++;
      if (n > 64) break;
    end
    check(tag, n, exp_q.pop_front());
    @(posedge clk); #1 idle();
  endtask

  task automatic do_reset();
    reset = 1; id_valid = 1; s1 = 5; s1_use = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_stall", int'(stall1), 0);
    check("rst_mask", int'(mask1), 0);
    check("rst_busy", int'(busy1), 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check("post_rst_stall", int'(stall1), 0);
    check("post_rst_mask", int'(mask1), 0);
    check("post_rst_busy", int'(busy1), 0);
    @(posedge clk); #1 idle();
  endtask

  initial begin
    int n;
    idle();
    reset = 1;
    @(posedge clk); #1;
    do_reset();

    // load lat 2 -> 1 stall
    issue(7, 2);
    id_valid = 1; s1 = 7; s1_use = 1;
    measure(0, "load_rs1", 1);
    @(negedge clk) check("load_mask7", int'(mask1[7]), 0);
    @(posedge clk); #1;

    // div lat 6 -> 5 stalls; ALU lat 1 -> none
    issue(9, 6);
    id_valid = 1; s2 = 9; s2_use = 1;
    measure(0, "div_rs2", 5);
    issue(12, 1);
    id_valid = 1; s1 = 12; s1_use = 1;
    measure(0, "alu_rs1", 0);

    // unknown-latency load held until writeback
    issue(4, 0);
    id_valid = 1; s1 = 4; s1_use = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall1) n++;
    end
    wb_valid = 1; wb_dest = 4;
    @(posedge clk); #1 wb_valid = 0;
    @(negedge clk);
    check("unk_stall_cycles", n, 20);
    check("unk_release", int'(stall1), 0);
    check("unk_mask4", int'(mask1[4]), 0);
    @(posedge clk); #1 idle();

    // issue of rd4 (unknown) beats a same-cycle writeback of 4
    id_valid = 1; we = 1; rd = 4; lat = 0; wb_valid = 1; wb_dest = 4;
    @(posedge clk); #1 idle();
    @(negedge clk) check("reissue_keeps_unk", int'(mask1[4]), 1);
    wb_valid = 1; wb_dest = 4;
    @(posedge clk); #1 wb_valid = 0;
    @(negedge clk) check("wb_clears_unk", int'(mask1[4]), 0);
    @(posedge clk); #1 idle();

    // WAW: lat-6 write then lat-1 write to the same rd
    issue(3, 6);
    id_valid = 1; we = 1; rd = 3; lat = 1;
    measure(0, "waw_rd3", 5);
    @(negedge clk) check("waw_mask3", int'(mask1[3]), 0);
    @(posedge clk); #1;

    // x0 as source and destination
    id_valid = 1; s1 = 0; s1_use = 1; s2 = 0; s2_use = 1; we = 1; rd = 0; lat = 5;
    measure(0, "x0_stall", 0);
    @(negedge clk);
    check("x0_mask0", int'(mask1[0]), 0);
    check("x0_busy", int'(busy1), 0);
    @(posedge clk); #1;

    // flushed write creates no entry; older entry keeps counting
    issue(11, 6);
    id_valid = 1; we = 1; rd = 10; lat = 4; flush = 1;
    @(posedge clk); #1 idle();
    @(negedge clk);
    check("flush_mask10", int'(mask1[10]), 0);
    n = 0;
    while (mask1[11] && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("flush_rd11_drain", n, 4);
    @(posedge clk); #1;

    // FORWARD_EN = 0 instance
    do_reset();
    issue(9, 6);
    id_valid = 1; s2 = 9; s2_use = 1;
    measure(1, "nofwd_div", 8);
    issue(12, 1);
    id_valid = 1; s1 = 12; s1_use = 1;
    measure(1, "nofwd_alu", 3);
    issue(13, 15);
    id_valid = 1; s1 = 13; s1_use = 1;
    measure(1, "nofwd_sat", 15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
